seq_mac: RTL and testbench
==========================

SEQ_MAC -- requirements
Module: seq_mac

Interface
REQ-001 SHALL have parameter WORD_SIZE, 16, operand and result width in bits.
REQ-002 SHALL have parameter BUS_WIDTH, 32, memory data width, fixed at 2*WORD_SIZE.
REQ-003 SHALL have parameter ADDR_WIDTH, 16, memory address width.
REQ-004 SHALL have parameter NUM_TERMS, 12, maximum products per operation.
REQ-005 SHALL have parameter SATURATE, 1; 1 = clamp opt, 0 = truncate opt.
REQ-006 SHALL derive LEN_W = clog2(NUM_TERMS+1) and ACC_W = 2*WORD_SIZE + clog2(NUM_TERMS).
REQ-007 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, begin operation; sampled in IDLE only.
REQ-010 SHALL have port signed_mode, input, 1, two's-complement operands when 1; latched with start.
REQ-011 SHALL have port base_addr, input, ADDR_WIDTH, first pair address; latched with start.
REQ-012 SHALL have port len, input, LEN_W, number of pairs; latched with start.
REQ-013 SHALL have port rd, output, 1, memory read strobe.
REQ-014 SHALL have port address, output, ADDR_WIDTH, memory read address.
REQ-015 SHALL have port bus, input, BUS_WIDTH, read data; wt = bus[BUS_WIDTH-1:WORD_SIZE], x = bus[WORD_SIZE-1:0].
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have port finish, output, 1, one-cycle completion pulse.
REQ-018 SHALL have port opt, output, WORD_SIZE, final result, held until next completion.
REQ-019 SHALL have port acc, output, ACC_W, full-precision accumulator, held with opt.
REQ-020 SHALL have port ovf, output, 1, set when opt differs from acc; held until next completion.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, DRAIN, DONE.
REQ-022 IDLE: start=1 latches inputs, clears accumulator, clamps len above NUM_TERMS to NUM_TERMS; next state FETCH if len>0, else DONE.
REQ-023 FETCH: on cycle k (k=0..len-1), rd=1 and address = base_addr+k mod 2^ADDR_WIDTH; after issuing k=len-1, next state DRAIN.
REQ-024 Memory read latency SHALL be exactly one cycle; data for the address issued in cycle k is accumulated on the edge ending cycle k+1.
REQ-025 DRAIN: rd=0; accumulates the last pair; next state DONE.
REQ-026 DONE: finish=1 for one cycle; opt, acc and ovf update on entry to DONE; next state IDLE.
REQ-027 Latency: finish SHALL be high exactly len+2 cycles after the edge sampling start (1 cycle when len=0).
REQ-028 Products: unsigned 2*WORD_SIZE bits when signed_mode=0; signed, sign-extended to ACC_W when signed_mode=1; the accumulator never overflows.
REQ-029 SATURATE=1: opt = acc clamped to [0, 2^WORD_SIZE-1] when unsigned or [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1] when signed.
REQ-030 SATURATE=0: opt = acc[WORD_SIZE-1:0].
REQ-031 len=0: acc=0, opt=0, ovf=0, no memory read issued.
REQ-032 start while busy SHALL be ignored; latched inputs are unaffected.
REQ-033 start in the same cycle as DONE SHALL be ignored; start is accepted again from the following IDLE cycle.
REQ-034 rd SHALL be 0 and address SHALL be held in every state except FETCH.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE, rd=0, address=0, busy=0, finish=0, opt=0, acc=0, ovf=0, and clear the internal accumulator.
REQ-036 Reset mid-operation SHALL abandon the operation with no finish pulse; the first start after rst_n rises begins a fresh operation.

Verification
REQ-037 Unsigned base_addr=0, len=2, mem[0]={13,6}, mem[1]={17,10} -> addresses 0,1; finish at cycle 4; opt=248, ovf=0.
REQ-038 Unsigned SATURATE=1, len=12, all words {0xFFFF,0xFFFF} -> acc=12*0xFFFE0001, opt=0xFFFF, ovf=1; with SATURATE=0, opt=0x000C, ovf=1.
REQ-039 Signed, len=2, pairs {-3,4},{5,2} -> acc=-2, opt=0xFFFE, ovf=0.
REQ-040 base_addr=0xFFFF, len=2 -> address 0xFFFF then 0x0000; len=0 -> no rd, finish after 1 cycle, opt=0.
REQ-041 Second start pulsed during FETCH with different len/base -> ignored; result matches the first operation only.
REQ-042 rst_n pulsed low during FETCH of a len=12 operation -> all outputs 0 at once, no finish; a subsequent len=2 run gives the REQ-037 result.

Source files
------------

// File: rtl/seq_mac.sv
// seq_mac: multiply-accumulate over up to NUM_TERMS {wt, x} word pairs read
// from a memory with one cycle of read latency. The final sum is presented
// at full precision on acc and reduced to WORD_SIZE bits on opt, either
// clamped (SATURATE=1) or truncated (SATURATE=0).
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last completion
// FETCH | one read per cycle; data from the previous cycle's read is summed
// DRAIN | no read; the pair returned for the last address is summed
// DONE  | one-cycle finish pulse; result registers were loaded on entry
module seq_mac #(
    parameter int WORD_SIZE  = 16,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_TERMS  = 12,
    parameter int SATURATE   = 1,
    localparam int LEN_W     = $clog2(NUM_TERMS + 1),
    localparam int ACC_W     = 2 * WORD_SIZE + $clog2(NUM_TERMS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_W-1:0]      len,
    output logic                  rd,
    output logic [ADDR_WIDTH-1:0] address,
    input  logic [BUS_WIDTH-1:0]  bus,
    output logic                  busy,
    output logic                  finish,
    output logic [WORD_SIZE-1:0]  opt,
    output logic [ACC_W-1:0]      acc,
    output logic                  ovf
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  sm_q, sm_d;
    logic                  vld_q, vld_d;
    logic [ACC_W-1:0]      sum_q, sum_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [WORD_SIZE-1:0]  opt_q, opt_d;
    logic                  ovf_q, ovf_d;

    logic [LEN_W-1:0]            len_c;
    logic [WORD_SIZE-1:0]        wt, x;
    logic [2*WORD_SIZE-1:0]      prod_u;
    logic signed [2*WORD_SIZE-1:0] prod_s;
    logic [ACC_W-1:0]            prod_ext, sum_next;
    logic                        fits;
    logic [WORD_SIZE-1:0]        clamp_v;

    assign len_c = (len > LEN_W'(NUM_TERMS)) ? LEN_W'(NUM_TERMS) : len;
    assign wt    = bus[BUS_WIDTH-1:WORD_SIZE];
    assign x     = bus[WORD_SIZE-1:0];

    // Product of the pair on the bus, widened to the accumulator, and the running sum.
    always_comb begin
        prod_u   = {{WORD_SIZE{1'b0}}, wt} * {{WORD_SIZE{1'b0}}, x};
        prod_s   = $signed({{WORD_SIZE{wt[WORD_SIZE-1]}}, wt}) *
                   $signed({{WORD_SIZE{x[WORD_SIZE-1]}}, x});
        prod_ext = sm_q ? {{(ACC_W-2*WORD_SIZE){prod_s[2*WORD_SIZE-1]}}, prod_s}
                        : {{(ACC_W-2*WORD_SIZE){1'b0}}, prod_u};
        sum_next = sum_q + prod_ext;
    end

    // Range check of the final sum against the opt range and the clamp value to use.
    always_comb begin
        if (sm_q) begin
            fits    = (sum_next[ACC_W-1:WORD_SIZE-1] == '0) ||
                      (sum_next[ACC_W-1:WORD_SIZE-1] == '1);
            clamp_v = sum_next[ACC_W-1] ? {1'b1, {(WORD_SIZE-1){1'b0}}}
                                        : {1'b0, {(WORD_SIZE-1){1'b1}}};
        end else begin
            fits    = (sum_next[ACC_W-1:WORD_SIZE] == '0);
            clamp_v = '1;
        end
    end

    // Next-state logic; the sum advances whenever read data arrived this cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        sm_d    = sm_q;
        sum_d   = vld_q ? sum_next : sum_q;
        acc_d   = acc_q;
        opt_d   = opt_q;
        ovf_d   = ovf_q;
        vld_d   = (state_q == FETCH);
        case (state_q)
            IDLE: begin
                if (start) begin
                    sm_d  = signed_mode;
                    sum_d = '0;
                    cnt_d = len_c;
                    if (len_c != '0) begin
                        addr_d  = base_addr;
                        state_d = FETCH;
                    end else begin
                        acc_d   = '0;
                        opt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            FETCH: begin
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d  = cnt_q - LEN_W'(1);
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                acc_d   = sum_next;
                opt_d   = (fits || (SATURATE == 0)) ? sum_next[WORD_SIZE-1:0] : clamp_v;
                ovf_d   = ~fits;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            sm_q    <= 1'b0;
            vld_q   <= 1'b0;
            sum_q   <= '0;
            acc_q   <= '0;
            opt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sm_q    <= sm_d;
            vld_q   <= vld_d;
            sum_q   <= sum_d;
            acc_q   <= acc_d;
            opt_q   <= opt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rd      = (state_q == FETCH);
    assign address = addr_q;
    assign busy    = (state_q != IDLE);
    assign finish  = (state_q == DONE);
    assign opt     = opt_q;
    assign acc     = acc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_seq_mac.sv
// Bench for seq_mac: two instances (clamping and truncating) share one memory
// model. A timeline model predicts every output each cycle from the operation
// parameters captured when start is accepted.
module tb_seq_mac;

    localparam int W    = 16;
    localparam int BW   = 32;
    localparam int AW   = 16;
    localparam int NT   = 12;
    localparam int LW   = 4;
    localparam int ACCW = 36;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          signed_mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len = '0;
    logic [BW-1:0] bus = '0;

    logic            rd, rd0, busy, busy0, finish, finish0, ovf, ovf0;
    logic [AW-1:0]   address, address0;
    logic [W-1:0]    opt, opt0;
    logic [ACCW-1:0] acc, acc0;

    logic [BW-1:0] mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    seq_mac #(.WORD_SIZE(W), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .NUM_TERMS(NT), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .base_addr(base_addr), .len(len), .rd(rd), .address(address), .bus(bus),
        .busy(busy), .finish(finish), .opt(opt), .acc(acc), .ovf(ovf));

    seq_mac #(.WORD_SIZE(W), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .NUM_TERMS(NT), .SATURATE(0)) dut_tr (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .base_addr(base_addr), .len(len), .rd(rd0), .address(address0), .bus(bus),
        .busy(busy0), .finish(finish0), .opt(opt0), .acc(acc0), .ovf(ovf0));

    always #5 clk = ~clk;

    // Memory: one cycle read latency, junk on the bus when nothing was read.
    always @(posedge clk) begin
        if (rd) bus <= mem[address];
        else    bus <= $urandom;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint prod(input logic [BW-1:0] w, input bit sm);
        logic [W-1:0] a, b;
        a = w[BW-1:W];
        b = w[W-1:0];
        if (sm) return longint'($signed(a)) * longint'($signed(b));
        return longint'(a) * longint'(b);
    endfunction

    task automatic reduce(input longint a, input bit sm,
                          output logic [W-1:0] o_sat, output logic [W-1:0] o_tr, output bit ov);
        longint lo, hi;
        lo    = sm ? -32768 : 0;
        hi    = sm ? 32767 : 65535;
        ov    = (a < lo) || (a > hi);
        o_tr  = a[W-1:0];
        o_sat = (a < lo) ? lo[W-1:0] : (a > hi) ? hi[W-1:0] : a[W-1:0];
    endtask

    // Timeline model: t counts cycles since the accepted start.
    // t=1..L reads, finish at t=L+2 (t=1 when L=0).
    bit            m_act = 0;
    bit            m_sm = 0;
    int            m_t = 0, m_tdone = 0, m_L = 0;
    logic [AW-1:0] m_base = '0, m_addr = '0;
    longint        r_acc = 0;
    logic [W-1:0]  r_opt = '0, r_opt0 = '0, m_opt = '0, m_opt0 = '0;
    bit            r_ovf = 0, m_ovf = 0;
    logic [ACCW-1:0] m_acc = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_t = 0; m_L = 0; m_addr = '0;
            m_acc = '0; m_opt = '0; m_opt0 = '0; m_ovf = 0;
        end else begin
            if (m_act) begin
                if (m_t == m_tdone) m_act = 0;
                else m_t++;
            end else if (start) begin
                m_L    = (int'(len) > NT) ? NT : int'(len);
                m_base = base_addr;
                m_sm   = signed_mode;
                r_acc  = 0;
                for (int k = 0; k < m_L; k++) r_acc += prod(mem[m_base + AW'(k)], m_sm);
                reduce(r_acc, m_sm, r_opt, r_opt0, r_ovf);
                m_tdone = (m_L == 0) ? 1 : m_L + 2;
                m_t     = 1;
                m_act   = 1;
            end
            if (m_act && m_t <= m_L) m_addr = m_base + AW'(m_t - 1);
            if (m_act && m_t == m_tdone) begin
                m_acc = r_acc[ACCW-1:0]; m_opt = r_opt; m_opt0 = r_opt0; m_ovf = r_ovf;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("rd",        rd,       m_act && m_t <= m_L);
        chk("address",   address,  m_addr);
        chk("busy",      busy,     m_act);
        chk("finish",    finish,   m_act && m_t == m_tdone);
        chk("acc",       acc,      m_acc);
        chk("opt",       opt,      m_opt);
        chk("ovf",       ovf,      m_ovf);
        chk("tr_rd",     rd0,      m_act && m_t <= m_L);
        chk("tr_finish", finish0,  m_act && m_t == m_tdone);
        chk("tr_acc",    acc0,     m_acc);
        chk("tr_opt",    opt0,     m_opt0);
        chk("tr_ovf",    ovf0,     m_ovf);
    end

    logic [AW-1:0] seen_addr [$];
    int            fin_cyc;

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    // Start one operation; optionally pulse a competing start during FETCH.
    task automatic run_op(input logic [AW-1:0] b, input logic [LW-1:0] l, input bit sm, input bit dstart);
        seen_addr.delete();
        fin_cyc = -1;
        wait_idle();
        base_addr = b; len = l; signed_mode = sm; start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = dstart;
                if (dstart) begin base_addr = 16'h0100; len = 4'd5; signed_mode = 1'b1; end
            end
            if (n == 2) start = 1'b0;
            if (rd) seen_addr.push_back(address);
            if (finish) begin fin_cyc = n; break; end
        end
        if (fin_cyc < 0) chk("finish_timeout", 0, 1);
    endtask

    task automatic check_037(input string tag);
        chk({tag, "_latency"}, fin_cyc, 4);
        chk({tag, "_nreads"}, seen_addr.size(), 2);
        if (seen_addr.size() == 2) begin
            chk({tag, "_addr0"}, seen_addr[0], 16'h0000);
            chk({tag, "_addr1"}, seen_addr[1], 16'h0001);
        end
        chk({tag, "_opt"}, opt, 16'd248);
        chk({tag, "_acc"}, acc, 36'd248);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        logic [AW-1:0] b;
        logic [LW-1:0] l;
        bit            sm;
        int            hold, kind;
        for (int i = 0; i < 65536; i++) mem[i] = '0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_opt", opt, 0);
        chk("rst_acc", acc, 0);
        rst_n = 1'b1;

        mem[0] = {16'd13, 16'd6};
        mem[1] = {16'd17, 16'd10};
        run_op(16'h0000, 4'd2, 1'b0, 1'b0);
        check_037("basic");

        run_op(16'h0000, 4'd2, 1'b0, 1'b1);
        check_037("ignore_start");

        for (int k = 0; k < 12; k++) mem[16'h0100 + k] = 32'hFFFF_FFFF;
        run_op(16'h0100, 4'd12, 1'b0, 1'b0);
        chk("full_latency", fin_cyc, 14);
        chk("full_acc", acc, 36'hB_FFE8_000C);
        chk("full_opt_sat", opt, 16'hFFFF);
        chk("full_opt_trunc", opt0, 16'h000C);
        chk("full_ovf", ovf, 1);
        chk("full_ovf_trunc", ovf0, 1);

        // Reset during FETCH of a 12-term operation.
        wait_idle();
        base_addr = 16'h0100; len = 4'd12; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd", rd, 0);
        chk("arst_address", address, 0);
        chk("arst_busy", busy, 0);
        chk("arst_finish", finish, 0);
        chk("arst_opt", opt, 0);
        chk("arst_acc", acc, 0);
        chk("arst_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0000, 4'd2, 1'b0, 1'b0);
        check_037("after_rst");

        mem[16'h0200] = {16'hFFFD, 16'd4};
        mem[16'h0201] = {16'd5, 16'd2};
        run_op(16'h0200, 4'd2, 1'b1, 1'b0);
        chk("signed_acc", acc, 36'hF_FFFF_FFFE);
        chk("signed_opt", opt, 16'hFFFE);
        chk("signed_opt_trunc", opt0, 16'hFFFE);
        chk("signed_ovf", ovf, 0);

        mem[16'h0300] = 32'h8000_8000;
        mem[16'h0301] = 32'h8000_8000;
        run_op(16'h0300, 4'd2, 1'b1, 1'b0);
        chk("sclamp_acc", acc, 36'h0_8000_0000);
        chk("sclamp_opt", opt, 16'h7FFF);
        chk("sclamp_opt_trunc", opt0, 16'h0000);
        chk("sclamp_ovf", ovf, 1);

        mem[16'hFFFF] = {16'd2, 16'd3};
        run_op(16'hFFFF, 4'd2, 1'b0, 1'b0);
        chk("wrap_nreads", seen_addr.size(), 2);
        if (seen_addr.size() == 2) begin
            chk("wrap_addr0", seen_addr[0], 16'hFFFF);
            chk("wrap_addr1", seen_addr[1], 16'h0000);
        end
        chk("wrap_opt", opt, 16'd84);

        run_op(16'h1234, 4'd0, 1'b0, 1'b0);
        chk("len0_latency", fin_cyc, 1);
        chk("len0_nreads", seen_addr.size(), 0);
        chk("len0_opt", opt, 0);
        chk("len0_acc", acc, 0);
        chk("len0_ovf", ovf, 0);

        // Randomized operations; the per-cycle compare does the checking.
        for (int i = 0; i < 60; i++) begin
            wait_idle();
            b    = AW'($urandom);
            l    = LW'($urandom_range(0, 15));
            sm   = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 2);
            for (int k = 0; k < NT; k++) begin
                logic [BW-1:0] w;
                w = $urandom;
                if (kind == 1) begin
                    case ($urandom_range(0, 3))
                        0: w[BW-1:W] = 16'hFFFF; 1: w[BW-1:W] = 16'h8000;
                        2: w[BW-1:W] = 16'h7FFF; default: w[BW-1:W] = 16'h0000;
                    endcase
                    w[W-1:0] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'hFFFF;
                end else if (kind == 2) begin
                    w = {16'($urandom_range(0, 300)), 16'($urandom_range(0, 300))};
                end
                mem[b + AW'(k)] = w;
            end
            base_addr = b; len = l; signed_mode = sm; start = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                hold = $urandom_range(1, 20);
                repeat (hold) @(negedge clk);
            end else begin
                hold = $urandom_range(1, 16);
                for (int n = 0; n < hold; n++) begin
                    @(negedge clk);
                    start = ($urandom_range(0, 3) == 0);
                    if (start) begin
                        base_addr = AW'($urandom); len = LW'($urandom); signed_mode = 1'($urandom);
                    end
                end
            end
            start = 1'b0;
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
